vec_fifo_v2: RTL and testbench

Parametrised vector FIFO with valid/ready handshakes on both sides, arbitrary (non-power-of-two) depth, configurable element width and synchronous flush. It is the general-purpose staging buffer between vector-producing and vector-consuming pipeline stages, such as a weight/activation fetch and a MAC array. Read side is first-word-fall-through. An optional level-reporting feature exposes occupancy and almost-full/almost-empty flags for upstream throttling.

---
 rtl/vec_fifo_v2.sv | 98 +++++++++
 tb/tb_vec_fifo_v2.sv | 191 +++++++++++++++++++
 2 files changed

// File: rtl/vec_fifo_v2.sv
// vec_fifo_v2: FWFT vector FIFO with arbitrary depth and valid/ready on both sides.
// Define VEC_FIFO_LEVEL_EN to add level_out, almost_full and almost_empty.
module vec_fifo_v2 #(
    parameter int VecElements       = 4,
    parameter int ElemWidth         = 8,
    parameter int Depth             = 6,
    parameter int AlmostFullThresh  = Depth - 1,
    parameter int AlmostEmptyThresh = 1
) (
    input  logic                                  clk_in,
    input  logic                                  rst_in,
    input  logic                                  flush_in,
    input  logic [VecElements-1:0][ElemWidth-1:0] in_data,
    input  logic                                  in_valid,
    output logic                                  in_ready,
    output logic [VecElements-1:0][ElemWidth-1:0] out_data,
    output logic                                  out_valid,
`ifdef VEC_FIFO_LEVEL_EN
    input  logic                                  out_ready,
    output logic [$clog2(Depth+1)-1:0]            level_out,
    output logic                                  almost_full,
    output logic                                  almost_empty
`else
    input  logic                                  out_ready
`endif
);

    localparam int PW = $clog2(Depth);
    localparam int CW = $clog2(Depth + 1);

    localparam logic [PW-1:0] LastPtr = PW'(Depth - 1);
    localparam logic [CW-1:0] FullCnt = CW'(Depth);

    typedef logic [VecElements-1:0][ElemWidth-1:0] word_t;

    word_t          mem [Depth];
    logic [PW-1:0]  wr_ptr;
    logic [PW-1:0]  rd_ptr;
    logic [CW-1:0]  count;
    logic           full;
    logic           empty;
    logic           wr_fire;
    logic           rd_fire;
    logic           wr_en;

    // Depth need not be a power of two, so wrap explicitly at Depth-1.
    function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
        return (p == LastPtr) ? '0 : p + 1'b1;
    endfunction

    assign full      = (count == FullCnt);
    assign empty     = (count == '0);
    assign in_ready  = !full;
    assign out_valid = !empty;
    assign out_data  = mem[rd_ptr];

    assign wr_fire = in_valid && in_ready;
    assign rd_fire = out_valid && out_ready;
    assign wr_en   = wr_fire && rst_in && !flush_in;

    always_ff @(posedge clk_in) begin
        if (!rst_in) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else if (flush_in) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (wr_fire) wr_ptr <= ptr_inc(wr_ptr);
            if (rd_fire) rd_ptr <= ptr_inc(rd_ptr);
            unique case ({wr_fire, rd_fire})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    // Storage is deliberately left unreset; pointers and count define validity.
    always_ff @(posedge clk_in) begin
        if (wr_en) mem[wr_ptr] <= in_data;
    end

`ifdef VEC_FIFO_LEVEL_EN
    localparam logic [CW-1:0] AfCnt = CW'(AlmostFullThresh);
    localparam logic [CW-1:0] AeCnt = CW'(AlmostEmptyThresh);

    assign level_out    = count;
    assign almost_full  = (count >= AfCnt);
    assign almost_empty = (count <= AeCnt);
`else
    logic unused_thresh;
    assign unused_thresh = ^{AlmostFullThresh, AlmostEmptyThresh};
`endif

endmodule

// File: tb/tb_vec_fifo_v2.sv
// tb_vec_fifo_v2: directed bench for vec_fifo_v2 (Depth 6, 4x8-bit words).
// Level outputs are checked only when VEC_FIFO_LEVEL_EN is defined.
module tb_vec_fifo_v2;

    localparam int D = 6;

    logic            clk_in = 1'b0;
    logic            rst_in;
    logic            flush_in;
    logic [3:0][7:0] in_data;
    logic            in_valid;
    logic            in_ready;
    logic [3:0][7:0] out_data;
    logic            out_valid;
    logic            out_ready;
`ifdef VEC_FIFO_LEVEL_EN
    logic [2:0]      level_out;
    logic            almost_full;
    logic            almost_empty;
`endif

    int n_cmp = 0;
    int n_err = 0;
    logic [31:0] q[$];

    always #5 clk_in = ~clk_in;

    vec_fifo_v2 #(
        .VecElements(4),
        .ElemWidth(8),
        .Depth(D)
    ) dut (
        .clk_in(clk_in),
        .rst_in(rst_in),
        .flush_in(flush_in),
        .in_data(in_data),
        .in_valid(in_valid),
        .in_ready(in_ready),
        .out_data(out_data),
        .out_valid(out_valid),
`ifdef VEC_FIFO_LEVEL_EN
        .out_ready(out_ready),
        .level_out(level_out),
        .almost_full(almost_full),
        .almost_empty(almost_empty)
`else
        .out_ready(out_ready)
`endif
    );

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic chk_state(input string tag);
        chk({tag, "_ovld"}, 32'(out_valid), 32'(q.size() > 0));
        chk({tag, "_irdy"}, 32'(in_ready), 32'(q.size() < D));
        if (q.size() > 0) chk({tag, "_odat"}, out_data, q[0]);
`ifdef VEC_FIFO_LEVEL_EN
        chk({tag, "_lvl"}, 32'(level_out), 32'(q.size()));
        chk({tag, "_af"}, 32'(almost_full), 32'(q.size() >= D - 1));
        chk({tag, "_ae"}, 32'(almost_empty), 32'(q.size() <= 1));
`endif
    endtask

    // One clock: drive at negedge, apply model at posedge, check at negedge.
    task automatic cyc(input logic rst, input logic fl, input logic iv,
                       input logic [31:0] d, input logic ordy,
                       input string tag, output logic wrote);
        logic wr;
        logic rd;
        rst_in    = rst;
        flush_in  = fl;
        in_valid  = iv;
        in_data   = d;
        out_ready = ordy;
        wr = iv && (q.size() < D);
        rd = ordy && (q.size() > 0);
        @(posedge clk_in);
        wrote = 1'b0;
        if (!rst || fl) begin
            q.delete();
        end else begin
            if (rd) void'(q.pop_front());
            if (wr) begin
                q.push_back(d);
                wrote = 1'b1;
            end
        end
        @(negedge clk_in);
        chk_state(tag);
    endtask

    initial begin
        logic w;
        int   wn;
        rst_in    = 1'b0;
        flush_in  = 1'b0;
        in_valid  = 1'b0;
        in_data   = '0;
        out_ready = 1'b0;
        @(negedge clk_in);
        cyc(0, 0, 0, 0, 0, "rst1", w);
        cyc(0, 0, 0, 0, 0, "rst2", w);
        chk("rst_ovld", 32'(out_valid), 0);
        chk("rst_irdy", 32'(in_ready), 1);

        // Fill with out_ready low.
        for (int i = 1; i <= D; i++)
            cyc(1, 0, 1, {4{8'(i)}}, 0, "fill", w);
        chk("full_irdy", 32'(in_ready), 0);
        chk("full_head", out_data, 32'h01010101);
`ifdef VEC_FIFO_LEVEL_EN
        chk("full_lvl", 32'(level_out), 6);
        chk("full_af", 32'(almost_full), 1);
`endif
        // Blocked write while full is dropped.
        cyc(1, 0, 1, 32'hDEADBEEF, 0, "blk", w);

        // Drain in order.
        for (int i = 1; i <= D; i++) begin
            chk("drain_dat", out_data, {4{8'(i)}});
            cyc(1, 0, 0, 0, 1, "drain", w);
        end
        chk("drained_ovld", 32'(out_valid), 0);

        // Write while empty: no bypass in same cycle.
        in_valid = 1'b1;
        in_data  = 32'h11111111;
        #1;
        chk("nobypass", 32'(out_valid), 0);
        cyc(1, 0, 1, 32'h11111111, 0, "w1", w);
        cyc(1, 0, 1, 32'h12121212, 0, "w2", w);
        cyc(1, 0, 1, 32'h13131313, 0, "w3", w);

        // Concurrent read/write at count 3.
        for (int i = 0; i < 10; i++)
            cyc(1, 0, 1, 32'h30000000 + i, 1, "conc", w);
        chk("conc_head", out_data, 32'h30000007);

        // Fill up, then both sides active when full: only the read fires.
        for (int i = 0; i < 3; i++)
            cyc(1, 0, 1, 32'h40000000 + i, 0, "top", w);
        chk("top_irdy", 32'(in_ready), 0);
        cyc(1, 0, 1, 32'h4FFFFFFF, 1, "fullrw", w);
        chk("fullrw_irdy", 32'(in_ready), 1);
        chk("fullrw_head", out_data, 32'h30000008);

        // Random duty wrap-around: 20 words through the FIFO.
        cyc(1, 1, 0, 0, 0, "pflush", w);
        wn = 0;
        for (int c = 0; c < 400 && wn < 20; c++) begin
            cyc(1, 0, 1'($urandom_range(0, 1)) , 32'h50000000 + wn,
                1'($urandom_range(0, 1)), "rnd", w);
            if (w) wn++;
        end
        chk("rnd_words", wn, 20);
        for (int c = 0; c < 20 && q.size() > 0; c++)
            cyc(1, 0, 0, 0, 1, "rdrain", w);
        chk("rnd_empty", 32'(out_valid), 0);

        // Flush with count 4 and a concurrent write.
        for (int i = 0; i < 4; i++)
            cyc(1, 0, 1, 32'h60000000 + i, 0, "pf", w);
        cyc(1, 1, 1, 32'h6FFFFFFF, 1, "flush", w);
        chk("flush_ovld", 32'(out_valid), 0);
        chk("flush_irdy", 32'(in_ready), 1);
        cyc(1, 0, 1, 32'h61616161, 0, "postfl", w);
        chk("postfl_head", out_data, 32'h61616161);

        // Mid-operation reset at count 3 with in_valid high.
        cyc(1, 0, 1, 32'h70000000, 0, "pr", w);
        cyc(1, 0, 1, 32'h70000001, 0, "pr", w);
        cyc(0, 0, 1, 32'h7FFFFFFF, 1, "mrst", w);
        chk("mrst_ovld", 32'(out_valid), 0);
        chk("mrst_irdy", 32'(in_ready), 1);
        cyc(1, 0, 1, 32'hAABBCCDD, 0, "after", w);
        chk("after_head", out_data, 32'hAABBCCDD);
        cyc(1, 0, 0, 0, 1, "after_rd", w);
        chk("after_empty", 32'(out_valid), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
